signed_sar_search: RTL and testbench
====================================

SIGNED_SAR_SEARCH -- requirements
Module: signed_sar_search

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, named as in the rest of the codebase.
REQ-002 Port `clk`, input, 1 bit: the clock; all state changes on the rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `start`, input, 1 bit: request a new search; sampled only in IDLE.
REQ-005 Port `gt`, input, 1 bit: result from the external comparator.
- 1 when $signed(secret) > $signed(probe).
- Combinational with respect to `probe`.
- Sampled on the same edge that ends the PROBE cycle.
REQ-006 Port `probe`, output, 4 bits: the signed candidate value driven to the comparator.
REQ-007 Port `probe_valid`, output, 1 bit: high exactly in PROBE cycles.
REQ-008 Port `busy`, output, 1 bit: high in PROBE and DONE.
REQ-009 Port `done`, output, 1 bit: one-cycle pulse in DONE.
REQ-010 Port `result`, output, 4 bits, signed: the found value; holds until the next search completes.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, PROBE, DONE.
REQ-012 IDLE with start=1 SHALL go to PROBE and load the search bounds and step counter:
- lo=-8, hi=+7, held as 5-bit signed.
- step=0.
REQ-013 IDLE with start=0 SHALL remain in IDLE.
REQ-014 In PROBE, probe SHALL be the low 4 bits of mid = (lo+hi) arithmetic-shift-right 1.
- The sum is 5-bit signed, so mid is the floor of the average.
REQ-015 In PROBE, each edge SHALL update the bounds from `gt` and increment step:
- gt=1: lo <= mid+1.
- gt=0: hi <= mid.
REQ-016 The search SHALL take exactly 4 PROBE cycles; after the edge ending step 3, the FSM goes to DONE and result <= the final lo (lo==hi).
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency: start sampled at edge N gives PROBE at N+1..N+4, done=1 in cycle N+5, and the earliest next accepted start at edge N+6.
REQ-019 A start asserted in PROBE or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 Outside PROBE, probe SHALL read 0 and probe_valid 0.
REQ-021 The module SHALL NOT check gt for consistency: the result is whatever the 4-step halving yields, and lo/hi cannot leave -8..+7.
REQ-022 The probe value SHALL always lie in -8..+6.

Reset
REQ-023 While reset is asserted, independent of clk, the module SHALL force:
- state=IDLE.
- lo=-8, hi=7, step=0.
- result=0.
- probe=0, probe_valid=0, busy=0, done=0.
REQ-024 Reset asserted during PROBE or DONE SHALL abort the search, with no done pulse and result=0.
REQ-025 The first start after reset deasserts SHALL be accepted on the next rising edge.

Structure
REQ-026 The shared package SHALL hold:
- Operand width constant W=4.
- Internal bound width W+1.
- Step count 4.
- The three state encodings.
REQ-027 The block SHALL contain no sub-module: the comparator is external, and the bench SHALL supply a behavioural signed 4-bit comparator driven by `probe` and a secret value.
REQ-028 The bench SHALL provide the gt path with no added register stage.

Verification
REQ-029 Secret=-8, start pulse -> probes -1,-5,-7,-8; done in cycle 5 after start; result=-8 (0x8).
REQ-030 Secret=+7 -> probes -1,3,5,6; result=7.
REQ-031 Secret=0 -> probes -1,3,1,0; result=0; all 16 secrets -8..+7 in sequence each give result=secret.
REQ-032 start held high continuously -> done pulses every 6 cycles; start during busy never alters probes.
REQ-033 Reset asserted in the 2nd PROBE cycle, between edges -> all outputs 0 immediately, no done; the next search for secret=-3 returns -3.
REQ-034 After a completed search (result=5), with start low for 10 cycles -> result stays 5 and busy/done stay 0.

Source files
------------

// File: rtl/signed_sar_search_pkg.sv
// Shared constants and state encoding for the signed successive-approximation search.
package signed_sar_search_pkg;

  // Operand width of the signed value being searched for.
  localparam int W = 4;
  // Bounds carry one extra bit so lo+hi cannot overflow.
  localparam int BW = W + 1;
  // One probe per operand bit.
  localparam int NSTEPS = 4;
  localparam int SW = $clog2(NSTEPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/signed_sar_search.sv
// Binary search for a signed W-bit secret using an external "secret > probe" comparator.
module signed_sar_search
  import signed_sar_search_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                gt,
  output logic [W-1:0]        probe,
  output logic                probe_valid,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] result
);

  localparam logic signed [BW-1:0] LO_INIT = BW'(-(2 ** (W - 1)));
  localparam logic signed [BW-1:0] HI_INIT = BW'((2 ** (W - 1)) - 1);
  localparam logic signed [BW-1:0] ONE     = BW'(1);

  state_t               state_q, state_d;
  logic signed [BW-1:0] lo_q, lo_d;
  logic signed [BW-1:0] hi_q, hi_d;
  logic signed [BW-1:0] sum, mid;
  logic [SW-1:0]        step_q, step_d;
  logic signed [W-1:0]  result_q, result_d;

  // Next-state, bound update and output decode; outputs are pure functions of state
  // so an asynchronous reset clears them immediately.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    step_d      = step_q;
    result_d    = result_q;
    sum         = lo_q + hi_q;
    mid         = sum >>> 1;
    probe       = '0;
    probe_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PROBE;
          lo_d    = LO_INIT;
          hi_d    = HI_INIT;
          step_d  = '0;
        end
      end
      PROBE: begin
        probe       = mid[W-1:0];
        probe_valid = 1'b1;
        busy        = 1'b1;
        if (gt) lo_d = mid + ONE;
        else    hi_d = mid;
        step_d = step_q + SW'(1);
        // Result captures the bound after the last update, when lo and hi have met.
        if (step_q == SW'(NSTEPS - 1)) begin
          state_d  = DONE;
          result_d = lo_d[W-1:0];
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lo_q     <= LO_INIT;
      hi_q     <= HI_INIT;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_signed_sar_search.sv
// Scoreboard bench for signed_sar_search with a behavioural signed comparator.
module tb_signed_sar_search;

  logic              clk;
  logic              reset;
  logic              start;
  logic              gt;
  logic [3:0]        probe;
  logic              probe_valid;
  logic              busy;
  logic              done;
  logic signed [3:0] result;
  logic signed [3:0] secret;

  int n_vec;
  int n_err;
  int exp_probe_q[$];
  int exp_result_q[$];

  signed_sar_search dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .gt          (gt),
    .probe       (probe),
    .probe_valid (probe_valid),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // Comparator: combinational, no register stage.
  assign gt = (secret > $signed(probe));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Independent reference: textbook floor-average bisection on integers.
  task automatic push_model(input int s);
    int lo, hi, sm, md;
    lo = -8;
    hi = 7;
    for (int i = 0; i < 4; i++) begin
      sm = lo + hi;
      md = (sm >= 0) ? sm / 2 : -((-sm + 1) / 2);
      exp_probe_q.push_back(md);
      if (s > md) lo = md + 1;
      else        hi = md;
    end
    exp_result_q.push_back(lo);
  endtask

  task automatic push_fixed(input int p0, input int p1, input int p2, input int p3, input int r);
    exp_probe_q.push_back(p0);
    exp_probe_q.push_back(p1);
    exp_probe_q.push_back(p2);
    exp_probe_q.push_back(p3);
    exp_result_q.push_back(r);
  endtask

  // Counts falling edges until done is seen; -1 if the bound expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic run_search(input logic signed [3:0] s);
    int lat;
    secret = s;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("done_latency", lat, 5);
    chk("busy_in_done", int'(busy), 1);
    @(negedge clk);
    chk("probes_drained", exp_probe_q.size(), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  // Output monitor: pops expectations as the DUT produces probes and results.
  always @(negedge clk) begin
    if (probe_valid) begin
      if (exp_probe_q.size() == 0) chk("unexpected_probe", 1, 0);
      else chk("probe", int'($signed(probe)), exp_probe_q.pop_front());
    end
    if (done) begin
      if (exp_result_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("result", int'(result), exp_result_q.pop_front());
    end
  end

  initial begin
    int n;
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    secret = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_probe", int'(probe), 0);
    chk("rst_probe_valid", int'(probe_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;

    // Known vectors: extremes and zero.
    push_fixed(-1, -5, -7, -8, -8);
    run_search(-4'sd8);
    push_fixed(-1, 3, 5, 6, 7);
    run_search(4'sd7);
    push_fixed(-1, 3, 1, 0, 0);
    run_search(4'sd0);

    // Every secret in range.
    for (int s = -8; s <= 7; s++) begin
      push_model(s);
      run_search(4'(s));
    end

    // start held high: back-to-back searches every 6 cycles, no queued starts.
    secret = 4'sd4;
    for (int k = 0; k < 3; k++) push_model(4);
    @(negedge clk);
    start = 1'b1;
    wait_done(n);
    chk("held_first_done", int'(n > 0), 1);
    wait_done(n);
    chk("held_period_1", n, 6);
    wait_done(n);
    chk("held_period_2", n, 6);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_drained", exp_probe_q.size() + exp_result_q.size(), 0);
    chk("held_idle_busy", int'(busy), 0);

    // Reset in the middle of the second PROBE cycle.
    secret = 4'sd2;
    push_model(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_probe", int'(probe), 0);
    chk("abort_probe_valid", int'(probe_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    exp_probe_q.delete();
    exp_result_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push_model(-3);
    run_search(-4'sd3);

    // Result holds while idle.
    push_model(5);
    run_search(4'sd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_result", int'(result), 5);
      chk("hold_busy", int'(busy), 0);
      chk("hold_done", int'(done), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
